// File: rtl/usb_pkg.sv
// Shared encodings for the USB-style serial transmitter:
// framing states, line driver modes, SYNC pattern, J/K/SE0 levels and EOP lengths.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_e;

    typedef enum logic [1:0] {
        MODE_IDLE,
        MODE_BIT,
        MODE_SE0,
        MODE_J
    } line_mode_e;

    // SYNC is sent LSB first: seven 0s then a 1
    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Line levels as {dp, dn}
    localparam logic [1:0] LVL_J   = 2'b10;
    localparam logic [1:0] LVL_K   = 2'b01;
    localparam logic [1:0] LVL_SE0 = 2'b00;

    localparam int unsigned EOP_SE0_LEN = 2;
    localparam int unsigned EOP_J_LEN   = 1;

endpackage

// File: rtl/usb_bit_stuff_nrzi.sv
// Bit stuffing counter, NRZI line level and registered line drivers.
// Every state change happens only on bit strobes; the line holds otherwise.
module usb_bit_stuff_nrzi
    import usb_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic [1:0] mode,
    input  logic       raw_bit,
    output logic       stuff_c,
    output logic       owe_c,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe
);

    localparam int unsigned CNT_W = $clog2(STUFF_LEN + 1);

    logic [CNT_W-1:0] ones_q, ones_d;
    logic             level_q, level_d;
    logic [1:0]       line_q, line_d;
    logic             oe_q, oe_d;

    // This slot carries a stuffed 0 instead of a data bit
    assign stuff_c = (ones_q == CNT_W'(STUFF_LEN));
    // The current data 1 completes a run, so the next slot will be a stuff bit
    assign owe_c   = raw_bit && (ones_q == CNT_W'(STUFF_LEN - 1));

    always_comb begin
        ones_d  = ones_q;
        level_d = level_q;
        line_d  = line_q;
        oe_d    = oe_q;
        if (bit_en) begin
            case (mode)
                MODE_BIT: begin
                    if (stuff_c || !raw_bit) begin
                        level_d = ~level_q;
                        ones_d  = '0;
                    end else begin
                        ones_d  = ones_q + CNT_W'(1);
                    end
                    line_d = level_d ? LVL_J : LVL_K;
                    oe_d   = 1'b1;
                end
                MODE_SE0: begin
                    ones_d  = '0;
                    level_d = 1'b1;
                    line_d  = LVL_SE0;
                    oe_d    = 1'b1;
                end
                MODE_J: begin
                    ones_d  = '0;
                    level_d = 1'b1;
                    line_d  = LVL_J;
                    oe_d    = 1'b1;
                end
                default: begin
                    ones_d  = '0;
                    level_d = 1'b1;
                    line_d  = LVL_J;
                    oe_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ones_q  <= '0;
            level_q <= 1'b1;
            line_q  <= LVL_J;
            oe_q    <= 1'b0;
        end else begin
            ones_q  <= ones_d;
            level_q <= level_d;
            line_q  <= line_d;
            oe_q    <= oe_d;
        end
    end

    assign usb_dp = line_q[1];
    assign usb_dn = line_q[0];
    assign usb_oe = oe_q;

endmodule

// File: rtl/link_serial_t.sv
// Packet serializer: one-byte holding register, byte shifter and framing FSM
// (SYNC, stuffed NRZI data, EOP) driving a USB-style differential line.
module link_serial_t
    import usb_pkg::*;
#(
    parameter int unsigned STUFF_LEN = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_bit_en,
    input  logic       tx_to_sop,
    input  logic       tx_to_eop,
    input  logic       tx_to_valid,
    output logic       tx_to_ready,
    input  logic [7:0] tx_to_data,
    output logic       usb_dp,
    output logic       usb_dn,
    output logic       usb_oe,
    output logic       tx_err
);

    tx_state_e  state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [1:0] eop_cnt_q, eop_cnt_d;
    logic       cur_eop_q, cur_eop_d;
    logic [7:0] hold_data_q, hold_data_d;
    logic       hold_sop_q, hold_sop_d;
    logic       hold_eop_q, hold_eop_d;
    logic       tx_to_ready_q, tx_to_ready_d;
    logic       tx_err_q, tx_err_d;

    line_mode_e mode;
    logic       accept;
    logic       consume;
    logic       byte_done;
    logic       stuff_c;
    logic       owe_c;

    assign accept = tx_to_valid && tx_to_ready_q;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        eop_cnt_d     = eop_cnt_q;
        cur_eop_d     = cur_eop_q;
        hold_data_d   = hold_data_q;
        hold_sop_d    = hold_sop_q;
        hold_eop_d    = hold_eop_q;
        tx_to_ready_d = tx_to_ready_q;
        tx_err_d      = 1'b0;
        mode          = MODE_IDLE;
        consume       = 1'b0;
        byte_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The sop byte stays held until SYNC finishes; a non-sop byte is dropped
                if (tx_bit_en && !tx_to_ready_q) begin
                    if (hold_sop_q) begin
                        state_d   = ST_SYNC;
                        shift_d   = SYNC_PATTERN;
                        bit_cnt_d = 4'd0;
                        cur_eop_d = 1'b0;
                    end else begin
                        consume  = 1'b1;
                        tx_err_d = 1'b1;
                    end
                end
            end
            ST_SYNC, ST_DATA: begin
                mode = MODE_BIT;
                if (tx_bit_en) begin
                    if (stuff_c) begin
                        byte_done = (bit_cnt_q == 4'd8);
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        if (bit_cnt_q == 4'd7) begin
                            if (owe_c) bit_cnt_d = 4'd8;
                            else       byte_done = 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                    // Next byte is loaded on the very slot the current one ends
                    if (byte_done) begin
                        bit_cnt_d = 4'd0;
                        eop_cnt_d = 2'd0;
                        if (state_q == ST_DATA && cur_eop_q) begin
                            state_d = ST_EOP_SE0;
                        end else if (!tx_to_ready_q) begin
                            state_d   = ST_DATA;
                            shift_d   = hold_data_q;
                            cur_eop_d = hold_eop_q;
                            consume   = 1'b1;
                        end else begin
                            state_d  = ST_EOP_SE0;
                            tx_err_d = 1'b1;
                        end
                    end
                end
            end
            ST_EOP_SE0: begin
                mode = MODE_SE0;
                if (tx_bit_en) begin
                    if (eop_cnt_q == 2'(EOP_SE0_LEN - 1)) begin
                        state_d   = ST_EOP_J;
                        eop_cnt_d = 2'd0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end
            ST_EOP_J: begin
                mode = MODE_J;
                if (tx_bit_en) begin
                    if (eop_cnt_q == 2'(EOP_J_LEN - 1)) begin
                        state_d   = ST_IDLE;
                        eop_cnt_d = 2'd0;
                    end else begin
                        eop_cnt_d = eop_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (consume) begin
            tx_to_ready_d = 1'b1;
        end else if (accept) begin
            tx_to_ready_d = 1'b0;
            hold_data_d   = tx_to_data;
            hold_sop_d    = tx_to_sop;
            hold_eop_d    = tx_to_eop;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            shift_q       <= 8'd0;
            bit_cnt_q     <= 4'd0;
            eop_cnt_q     <= 2'd0;
            cur_eop_q     <= 1'b0;
            hold_data_q   <= 8'd0;
            hold_sop_q    <= 1'b0;
            hold_eop_q    <= 1'b0;
            tx_to_ready_q <= 1'b1;
            tx_err_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            eop_cnt_q     <= eop_cnt_d;
            cur_eop_q     <= cur_eop_d;
            hold_data_q   <= hold_data_d;
            hold_sop_q    <= hold_sop_d;
            hold_eop_q    <= hold_eop_d;
            tx_to_ready_q <= tx_to_ready_d;
            tx_err_q      <= tx_err_d;
        end
    end

    usb_bit_stuff_nrzi #(
        .STUFF_LEN (STUFF_LEN)
    ) u_line (
        .clk     (clk),
        .rst     (rst),
        .bit_en  (tx_bit_en),
        .mode    (mode),
        .raw_bit (shift_q[0]),
        .stuff_c (stuff_c),
        .owe_c   (owe_c),
        .usb_dp  (usb_dp),
        .usb_dn  (usb_dn),
        .usb_oe  (usb_oe)
    );

    assign tx_to_ready = tx_to_ready_q;
    assign tx_err      = tx_err_q;

endmodule

// File: tb/tb_link_serial_t.sv
// Directed bench for link_serial_t: table of packets with hand-derived line
// symbol strings (J, K, 0 = SE0), plus reset, drop and mid-packet reset sequences.
module tb_link_serial_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_bit_en;
    logic       tx_to_sop;
    logic       tx_to_eop;
    logic       tx_to_valid;
    logic       tx_to_ready;
    logic [7:0] tx_to_data;
    logic       usb_dp;
    logic       usb_dn;
    logic       usb_oe;
    logic       tx_err;

    logic en_half = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    typedef struct {
        string           name;
        int              n;
        logic [2:0][7:0] d;
        logic            last_eop;
        logic            half;
        int              exp_err;
        string           exp;
    } vec_t;

    vec_t vecs[6];

    link_serial_t #(.STUFF_LEN(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_bit_en   (tx_bit_en),
        .tx_to_sop   (tx_to_sop),
        .tx_to_eop   (tx_to_eop),
        .tx_to_valid (tx_to_valid),
        .tx_to_ready (tx_to_ready),
        .tx_to_data  (tx_to_data),
        .usb_dp      (usb_dp),
        .usb_dn      (usb_dn),
        .usb_oe      (usb_oe),
        .tx_err      (tx_err)
    );

    always #5 clk = ~clk;

    // Bit strobe: always on, or toggling every cycle for half rate
    initial begin
        tx_bit_en = 1'b1;
        forever begin
            @(negedge clk);
            if (en_half) tx_bit_en = ~tx_bit_en;
            else         tx_bit_en = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [1:0] sym(input byte c);
        case (c)
            "J":     sym = 2'b10;
            "K":     sym = 2'b01;
            default: sym = 2'b00;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input int n, input logic [2:0][7:0] d,
                                input logic last_eop, input logic half, input int exp_err,
                                input string exp);
        vec_t v;
        v.name = name; v.n = n; v.d = d; v.last_eop = last_eop;
        v.half = half; v.exp_err = exp_err; v.exp = exp;
        return v;
    endfunction

    task automatic send(input int n, input logic [2:0][7:0] d, input logic last_eop);
        int guard;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tx_to_valid = 1'b1;
            tx_to_data  = d[i];
            tx_to_sop   = (i == 0);
            tx_to_eop   = (i == n - 1) && last_eop;
            guard = 0;
            while (!tx_to_ready && guard < 300) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 300) check("send ready timeout", 32'(tx_to_ready), 32'd1);
        end
        @(negedge clk);
        tx_to_valid = 1'b0;
        tx_to_sop   = 1'b0;
        tx_to_eop   = 1'b0;
    endtask

    task automatic monitor(input string name, input string exp, input int exp_err);
        int   cyc;
        int   idx;
        int   errs;
        logic en;
        cyc = 0; errs = 0; idx = 0;
        while (!usb_oe && cyc < 200) begin
            @(posedge clk); #1;
            if (tx_err) errs++;
            cyc++;
        end
        if (!usb_oe) begin
            check($sformatf("%s oe rise", name), 32'(usb_oe), 32'd1);
            return;
        end
        check($sformatf("%s bit0", name), {usb_oe, usb_dp, usb_dn}, {1'b1, sym(exp.getc(0))});
        while (idx < exp.len() - 1 && cyc < 400) begin
            @(posedge clk);
            en = tx_bit_en;
            #1;
            cyc++;
            if (tx_err) errs++;
            if (en) idx++;
            check($sformatf("%s bit%0d%s", name, idx, en ? "" : " hold"),
                  {usb_oe, usb_dp, usb_dn}, {1'b1, sym(exp.getc(idx))});
        end
        if (idx < exp.len() - 1) check($sformatf("%s length", name), idx, exp.len() - 1);
        do begin
            @(posedge clk);
            en = tx_bit_en;
            #1;
            cyc++;
            if (tx_err) errs++;
        end while (!en && cyc < 500);
        check($sformatf("%s line idle", name), {usb_oe, usb_dp, usb_dn}, 3'b010);
        repeat (2) begin
            @(posedge clk); #1;
            if (tx_err) errs++;
        end
        check($sformatf("%s tx_err pulses", name), errs, exp_err);
    endtask

    task automatic run_vec(input int v);
        en_half = vecs[v].half;
        fork
            send(vecs[v].n, vecs[v].d, vecs[v].last_eop);
            monitor(vecs[v].name, vecs[v].exp, vecs[v].exp_err);
        join
        en_half = 1'b0;
        @(negedge clk);
        check($sformatf("%s ready after", vecs[v].name), 32'(tx_to_ready), 32'd1);
    endtask

    task automatic drop_test;
        int   errs;
        logic oe_seen;
        @(negedge clk);
        tx_to_valid = 1'b1;
        tx_to_sop   = 1'b0;
        tx_to_eop   = 1'b0;
        tx_to_data  = 8'h55;
        @(negedge clk);
        tx_to_valid = 1'b0;
        errs = 0; oe_seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (tx_err) errs++;
            if (usb_oe) oe_seen = 1'b1;
        end
        check("drop tx_err pulses", errs, 1);
        check("drop oe stays low", 32'(oe_seen), 32'd0);
        check("drop ready", 32'(tx_to_ready), 32'd1);
    endtask

    task automatic reset_mid_test;
        int cyc;
        send(2, {8'h00, 8'h01, 8'hFF}, 1'b1);
        cyc = 0;
        while (!usb_oe && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("pre-reset ready (holding full)", 32'(tx_to_ready), 32'd0);
        check("pre-reset oe", 32'(usb_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("mid reset {oe,dp,dn,ready,err}", {usb_oe, usb_dp, usb_dn, tx_to_ready, tx_err}, 5'b01010);
        @(negedge clk);
        check("mid reset held {oe,dp,dn,ready}", {usb_oe, usb_dp, usb_dn, tx_to_ready}, 4'b0101);
        rst = 1'b0;
    endtask

    initial begin
        string sync_w;
        sync_w      = "KJKJKJKK";
        rst         = 1'b1;
        tx_to_valid = 1'b0;
        tx_to_sop   = 1'b0;
        tx_to_eop   = 1'b0;
        tx_to_data  = 8'h00;

        // NRZI from K after SYNC; SYNC's final 1 starts the ones count
        vecs[0] = mk("ack", 1, {8'h00, 8'h00, 8'hD2}, 1'b1, 1'b0, 0,
                     {sync_w, "JJKJJKKK", "00J"});
        vecs[1] = mk("ack_half", 1, {8'h00, 8'h00, 8'hD2}, 1'b1, 1'b1, 0,
                     {sync_w, "JJKJJKKK", "00J"});
        vecs[2] = mk("stuff_ff01", 2, {8'h00, 8'h01, 8'hFF}, 1'b1, 1'b0, 0,
                     {sync_w, "KKKKKJJJJ", "JKJKJKJK", "00J"});
        vecs[3] = mk("token", 3, {8'h07, 8'h15, 8'hE1}, 1'b1, 1'b0, 0,
                     {sync_w, "KJKJKKKK", "KJJKKJKJ", "JJJKJKJK", "00J"});
        vecs[4] = mk("underrun", 1, {8'h00, 8'h00, 8'hD2}, 1'b0, 1'b0, 1,
                     {sync_w, "JJKJJKKK", "00J"});
        vecs[5] = mk("tail_stuff", 1, {8'h00, 8'h00, 8'hFC}, 1'b1, 1'b0, 0,
                     {sync_w, "JKKKKKKKJ", "00J"});

        repeat (2) @(negedge clk);
        check("reset ready", 32'(tx_to_ready), 32'd1);
        check("reset dp", 32'(usb_dp), 32'd1);
        check("reset dn", 32'(usb_dn), 32'd0);
        check("reset oe", 32'(usb_oe), 32'd0);
        check("reset tx_err", 32'(tx_err), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) run_vec(v);
        drop_test();
        reset_mid_test();
        run_vec(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
